// File: rtl/sccb_target_if.sv
// sccb_target_if: register-bus side of the SCCB target.
// The target drives the strobes, pointer, write data and busy flag;
// the register file (or bench) supplies read data.
`timescale 1ns/1ps
interface sccb_target_if;
    logic       o_wr_en;
    logic [7:0] o_addr;
    logic [7:0] o_wr_data;
    logic       o_rd_en;
    logic [7:0] i_rd_data;
    logic       o_busy;

    modport slave (
        output o_wr_en, o_addr, o_wr_data, o_rd_en, o_busy,
        input  i_rd_data
    );

    modport master (
        input  o_wr_en, o_addr, o_wr_data, o_rd_en, o_busy,
        output i_rd_data
    );
endinterface

// File: rtl/sccb_target.sv
// sccb_target: SCCB (I2C-like) responder exposing a simple register bus.
// SCL/SDA are oversampled on i_clk through 2-FF synchronisers plus one
// history stage for edge/START/STOP detection. SDA is only ever pulled low
// or released. The read path is built only when SCCB_TARGET_READ_EN is
// defined; otherwise read IDs are not acknowledged and o_rd_en stays 0.
`timescale 1ns/1ps
module sccb_target #(
    parameter logic [7:0] SLAVE_ID = 8'h42
) (
    input  logic         i_clk,
    input  logic         i_rst,
    input  logic         i_sclk,
    inout  wire          io_sda,
    sccb_target_if.slave bus
);

    localparam logic [3:0] ST_IDLE      = 4'd0;
    localparam logic [3:0] ST_ID        = 4'd1;
    localparam logic [3:0] ST_ID_ACK    = 4'd2;
    localparam logic [3:0] ST_ADDR      = 4'd3;
    localparam logic [3:0] ST_ADDR_ACK  = 4'd4;
    localparam logic [3:0] ST_WDATA     = 4'd5;
    localparam logic [3:0] ST_WDATA_ACK = 4'd6;
    localparam logic [3:0] ST_IGNORE    = 4'd9;
`ifdef SCCB_TARGET_READ_EN
    localparam logic [3:0] ST_RDATA     = 4'd7;
    localparam logic [3:0] ST_RD_NA     = 4'd8;
`endif

    // synchroniser and history stages
    logic scl_s1_q, scl_s2_q, scl_prev_q;
    logic sda_s1_q, sda_s2_q, sda_prev_q;

    // bus events
    logic scl_rise_s, scl_fall_s, start_s, stop_s;
    logic [7:0] byte_s;

    // FSM and datapath registers
    logic [3:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [7:0] rx_q, rx_d;
    logic       ack_ph_q, ack_ph_d;
    logic       rw_q, rw_d;
    logic       sda_drv_q, sda_drv_d;
    logic [7:0] addr_q, addr_d;
    logic [7:0] wr_data_q, wr_data_d;
    logic       wr_en_q, wr_en_d;
    logic       busy_q, busy_d;
`ifdef SCCB_TARGET_READ_EN
    logic       rd_en_q, rd_en_d;
    logic [7:0] tx_q, tx_d;
`endif

    // Open-drain SDA: pull low or release; reset clears the driver asynchronously.
    assign io_sda = sda_drv_q ? 1'b0 : 1'bz;

    assign scl_rise_s = scl_s2_q & ~scl_prev_q;
    assign scl_fall_s = ~scl_s2_q & scl_prev_q;
    assign start_s    = scl_s2_q & scl_prev_q & sda_prev_q & ~sda_s2_q;
    assign stop_s     = scl_s2_q & scl_prev_q & ~sda_prev_q & sda_s2_q;
    assign byte_s     = {rx_q[6:0], sda_s2_q};

    assign bus.o_wr_en   = wr_en_q;
    assign bus.o_addr    = addr_q;
    assign bus.o_wr_data = wr_data_q;
    assign bus.o_busy    = busy_q;
`ifdef SCCB_TARGET_READ_EN
    assign bus.o_rd_en   = rd_en_q;
`else
    assign bus.o_rd_en   = 1'b0;
`endif

    // Synchronise SCL/SDA and keep one previous sample; idle bus level is high.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            scl_s1_q   <= 1'b1;
            scl_s2_q   <= 1'b1;
            scl_prev_q <= 1'b1;
            sda_s1_q   <= 1'b1;
            sda_s2_q   <= 1'b1;
            sda_prev_q <= 1'b1;
        end else begin
            scl_s1_q   <= i_sclk;
            scl_s2_q   <= scl_s1_q;
            scl_prev_q <= scl_s2_q;
            sda_s1_q   <= io_sda;
            sda_s2_q   <= sda_s1_q;
            sda_prev_q <= sda_s2_q;
        end
    end

    // Transaction FSM: START/STOP take priority over any SCL edge.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        rx_d      = rx_q;
        ack_ph_d  = ack_ph_q;
        rw_d      = rw_q;
        sda_drv_d = sda_drv_q;
        addr_d    = addr_q;
        wr_data_d = wr_data_q;
        wr_en_d   = 1'b0;
`ifdef SCCB_TARGET_READ_EN
        rd_en_d   = 1'b0;
        if (rd_en_q) begin
            tx_d = bus.i_rd_data;
        end else begin
            tx_d = tx_q;
        end
`endif
        if (start_s) begin
            state_d   = ST_ID;
            cnt_d     = 3'd0;
            ack_ph_d  = 1'b0;
            sda_drv_d = 1'b0;
        end else if (stop_s) begin
            state_d   = ST_IDLE;
            ack_ph_d  = 1'b0;
            sda_drv_d = 1'b0;
        end else begin
            case (state_q)
                ST_ID: begin
                    if (scl_rise_s) begin
                        rx_d  = byte_s;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (byte_s[7:1] == SLAVE_ID[7:1]) begin
                                rw_d = byte_s[0];
`ifdef SCCB_TARGET_READ_EN
                                state_d = ST_ID_ACK;
`else
                                // Without the read path a read ID is left un-ACKed.
                                if (byte_s[0]) begin
                                    state_d = ST_IGNORE;
                                end else begin
                                    state_d = ST_ID_ACK;
                                end
`endif
                            end else begin
                                state_d = ST_IGNORE;
                            end
                        end else begin
                            state_d = ST_ID;
                        end
                    end else begin
                        state_d = ST_ID;
                    end
                end
                ST_ADDR, ST_WDATA: begin
                    if (scl_rise_s) begin
                        rx_d  = byte_s;
                        cnt_d = cnt_q + 3'd1;
                        if (cnt_q == 3'd7) begin
                            if (state_q == ST_ADDR) begin
                                addr_d  = byte_s;
                                state_d = ST_ADDR_ACK;
                            end else begin
                                wr_data_d = byte_s;
                                wr_en_d   = 1'b1;
                                state_d   = ST_WDATA_ACK;
                            end
                        end else begin
                            state_d = state_q;
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
                ST_ID_ACK, ST_ADDR_ACK, ST_WDATA_ACK: begin
                    // First fall (end of bit 8) starts the ACK, second fall (end of bit 9) ends it.
                    if (scl_fall_s) begin
                        if (!ack_ph_q) begin
                            ack_ph_d  = 1'b1;
                            sda_drv_d = 1'b1;
`ifdef SCCB_TARGET_READ_EN
                            if ((state_q == ST_ID_ACK) && rw_q) begin
                                rd_en_d = 1'b1;
                            end else begin
                                rd_en_d = 1'b0;
                            end
`endif
                        end else begin
                            ack_ph_d  = 1'b0;
                            sda_drv_d = 1'b0;
                            cnt_d     = 3'd0;
                            case (state_q)
                                ST_ID_ACK: begin
                                    if (rw_q) begin
`ifdef SCCB_TARGET_READ_EN
                                        // MSB goes out right after the ACK clock ends.
                                        state_d   = ST_RDATA;
                                        sda_drv_d = ~tx_q[7];
                                        tx_d      = {tx_q[6:0], 1'b0};
`else
                                        state_d   = ST_IGNORE;
`endif
                                    end else begin
                                        state_d = ST_ADDR;
                                    end
                                end
                                ST_ADDR_ACK: state_d = ST_WDATA;
                                default:     state_d = ST_IGNORE;
                            endcase
                        end
                    end else begin
                        state_d = state_q;
                    end
                end
`ifdef SCCB_TARGET_READ_EN
                ST_RDATA: begin
                    if (scl_fall_s) begin
                        if (cnt_q == 3'd7) begin
                            sda_drv_d = 1'b0;
                            state_d   = ST_RD_NA;
                        end else begin
                            sda_drv_d = ~tx_q[7];
                            tx_d      = {tx_q[6:0], 1'b0};
                            cnt_d     = cnt_q + 3'd1;
                        end
                    end else begin
                        state_d = ST_RDATA;
                    end
                end
                ST_RD_NA: begin
                    sda_drv_d = 1'b0;
                    if (scl_rise_s) begin
                        state_d = ST_IGNORE;
                    end else begin
                        state_d = ST_RD_NA;
                    end
                end
`endif
                ST_IDLE, ST_IGNORE: begin
                    sda_drv_d = 1'b0;
                end
                default: begin
                    state_d   = ST_IDLE;
                    sda_drv_d = 1'b0;
                    ack_ph_d  = 1'b0;
                end
            endcase
        end
        busy_d = (state_d != ST_IDLE);
    end

    // FSM state, bus outputs and the open-drain driver register.
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            state_q   <= ST_IDLE;
            cnt_q     <= 3'd0;
            rx_q      <= 8'h00;
            ack_ph_q  <= 1'b0;
            rw_q      <= 1'b0;
            sda_drv_q <= 1'b0;
            addr_q    <= 8'h00;
            wr_data_q <= 8'h00;
            wr_en_q   <= 1'b0;
            busy_q    <= 1'b0;
`ifdef SCCB_TARGET_READ_EN
            rd_en_q   <= 1'b0;
            tx_q      <= 8'h00;
`endif
        end else begin
            state_q   <= state_d;
            cnt_q     <= cnt_d;
            rx_q      <= rx_d;
            ack_ph_q  <= ack_ph_d;
            rw_q      <= rw_d;
            sda_drv_q <= sda_drv_d;
            addr_q    <= addr_d;
            wr_data_q <= wr_data_d;
            wr_en_q   <= wr_en_d;
            busy_q    <= busy_d;
`ifdef SCCB_TARGET_READ_EN
            rd_en_q   <= rd_en_d;
            tx_q      <= tx_d;
`endif
        end
    end

endmodule

// File: tb/tb_sccb_target.sv
// tb_sccb_target: bit-banged SCCB master, table of directed transactions,
// hand-written repeated-START and reset-during-ACK sequences, then random
// transactions predicted by a transaction-level model of the target.
`timescale 1ns/1ps
module tb_sccb_target;
    localparam int H = 16;  // i_clk cycles per SCL half period
`ifdef SCCB_TARGET_READ_EN
    localparam bit RD_EN = 1'b1;
`else
    localparam bit RD_EN = 1'b0;
`endif

    typedef struct packed {
        logic        rd;
        logic [2:0]  nb;
        logic [39:0] bytes;
        logic [7:0]  rdat;
        logic [4:0]  exp_ack;
        logic [1:0]  exp_wr;
        logic [1:0]  exp_rd;
        logic [7:0]  exp_addr;
        logic [7:0]  exp_wdata;
        logic [7:0]  exp_rdbyte;
    } vec_t;

    logic clk   = 1'b0;
    logic i_rst = 1'b0;
    logic m_scl = 1'b1;
    logic m_low = 1'b0;
    wire  sda_w;

    assign sda_w = m_low ? 1'b0 : 1'bz;
    pullup (sda_w);

    sccb_target_if bus();

    sccb_target dut (
        .i_clk  (clk),
        .i_rst  (i_rst),
        .i_sclk (m_scl),
        .io_sda (sda_w),
        .bus    (bus)
    );

    always #5 clk = ~clk;

    int n_cmp = 0;
    int n_bad = 0;

    // monitor counters (only the monitor writes these)
    int         wr_cnt = 0;
    int         rd_cnt = 0;
    int         drv_cnt = 0;
    logic [7:0] wr_addr_seen = 8'h00;
    logic [7:0] wr_data_seen = 8'h00;
    logic [7:0] rd_addr_seen = 8'h00;

    // read data is wrong until the request is seen, then correct
    int         rd_base = 0;
    logic [7:0] rd_val  = 8'h00;
    assign bus.i_rd_data = (rd_cnt != rd_base) ? rd_val : ~rd_val;

    // model state
    logic [7:0] ptr_m  = 8'h00;
    logic [7:0] wdat_m = 8'h00;

    always begin
        @(negedge clk);
        #1;
        if (bus.o_wr_en) begin
            wr_cnt++;
            wr_addr_seen = bus.o_addr;
            wr_data_seen = bus.o_wr_data;
        end
        if (bus.o_rd_en) begin
            rd_cnt++;
            rd_addr_seen = bus.o_addr;
        end
        if (!m_low && (sda_w == 1'b0)) drv_cnt++;
    end

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic sbit(input logic b, output logic s);
        m_low = ~b;
        tick(H / 2);
        m_scl = 1'b1;
        tick(H / 2);
        s = sda_w;
        tick(H / 2);
        m_scl = 1'b0;
        tick(H / 2);
    endtask

    task automatic do_start();
        m_low = 1'b0;
        m_scl = 1'b1;
        tick(H);
        m_low = 1'b1;
        tick(H);
        m_scl = 1'b0;
        tick(H / 2);
    endtask

    task automatic do_rstart();
        m_low = 1'b0;
        tick(H / 2);
        m_scl = 1'b1;
        tick(H);
        m_low = 1'b1;
        tick(H);
        m_scl = 1'b0;
        tick(H / 2);
    endtask

    task automatic do_stop(input logic chk);
        int n;
        m_low = 1'b1;
        tick(H / 2);
        m_scl = 1'b1;
        tick(H);
        if (chk) check("busy_before_stop", 32'(bus.o_busy), 32'd1);
        m_low = 1'b0;
        n = 0;
        do begin
            tick(1);
            n++;
        end while (bus.o_busy && (n < 20));
        if (chk) check("busy_fall_latency", 32'(n), 32'd3);
        tick(H);
    endtask

    task automatic send_byte(input logic [7:0] b, output logic ack);
        logic s;
        for (int i = 7; i >= 0; i--) sbit(b[i], s);
        sbit(1'b1, s);
        ack = ~s;
    endtask

    task automatic recv_byte(output logic [7:0] d, output logic na);
        logic s;
        for (int i = 7; i >= 0; i--) begin
            sbit(1'b1, s);
            d[i] = s;
        end
        sbit(1'b1, s);
        na = s;
    endtask

    task automatic apply(input vec_t v);
        int         w0, r0, d0;
        logic [4:0] acks;
        logic [7:0] rbyte;
        logic       na, a;
        w0 = wr_cnt;
        r0 = rd_cnt;
        d0 = drv_cnt;
        rd_val  = v.rdat;
        rd_base = rd_cnt;
        acks  = 5'b00000;
        rbyte = 8'h00;
        na    = 1'b0;
        do_start();
        for (int i = 0; i < int'(v.nb); i++) begin
            send_byte(v.bytes[39 - 8 * i -: 8], a);
            acks[i] = a;
        end
        if (v.rd) recv_byte(rbyte, na);
        do_stop(1'b1);
        check("ack_bits", 32'(acks), 32'(v.exp_ack));
        check("wr_strobes", 32'(wr_cnt - w0), 32'(v.exp_wr));
        check("rd_strobes", 32'(rd_cnt - r0), 32'(v.exp_rd));
        check("addr_ptr", 32'(bus.o_addr), 32'(v.exp_addr));
        check("wr_data_out", 32'(bus.o_wr_data), 32'(v.exp_wdata));
        check("strobes_idle", 32'({bus.o_wr_en, bus.o_rd_en}), 32'd0);
        if (v.exp_wr != 2'd0) begin
            check("wr_strobe_addr", 32'(wr_addr_seen), 32'(v.exp_addr));
            check("wr_strobe_data", 32'(wr_data_seen), 32'(v.exp_wdata));
        end
        if (v.rd) begin
            check("read_byte", 32'(rbyte), 32'(v.exp_rdbyte));
            check("na_released", 32'(na), 32'd1);
        end
        if (v.exp_rd != 2'd0) check("rd_strobe_addr", 32'(rd_addr_seen), 32'(v.exp_addr));
        if (v.exp_ack == 5'b00000) check("no_sda_drive", 32'(drv_cnt - d0), 32'd0);
    endtask

    // Transaction-level prediction from the protocol rules.
    task automatic predict(input logic [39:0] bytes, input int nb, input logic [7:0] rdat,
                           output vec_t v);
        logic [7:0] id;
        logic       match;
        id    = bytes[39:32];
        match = (id[7:1] == 7'h21);
        v = '0;
        v.rd = id[0];
        v.nb = 3'(nb);
        v.bytes = bytes;
        v.rdat = rdat;
        v.exp_rdbyte = 8'hFF;
        if (match && !id[0]) begin
            for (int i = 0; i < nb && i < 3; i++) v.exp_ack[i] = 1'b1;
            if (nb >= 2) ptr_m = bytes[31:24];
            if (nb >= 3) begin
                wdat_m = bytes[23:16];
                v.exp_wr = 2'd1;
            end
        end
        if (match && id[0] && RD_EN) begin
            v.exp_ack[0] = 1'b1;
            v.exp_rd = 2'd1;
            v.exp_rdbyte = rdat;
        end
        v.exp_addr  = ptr_m;
        v.exp_wdata = wdat_m;
    endtask

    initial begin
        vec_t       tbl [5];
        vec_t       v;
        logic       a, s;
        logic [7:0] idb;
        logic [3:0] abits;
        logic [7:0] id;
        logic [31:0] rnd;
        int         w0, nb, sel;

        tbl[0] = '{rd:1'b0, nb:3'd3, bytes:40'h4212800000, rdat:8'h00, exp_ack:5'b00111,
                   exp_wr:2'd1, exp_rd:2'd0, exp_addr:8'h12, exp_wdata:8'h80, exp_rdbyte:8'hFF};
        tbl[1] = '{rd:1'b0, nb:3'd3, bytes:40'h6012340000, rdat:8'h00, exp_ack:5'b00000,
                   exp_wr:2'd0, exp_rd:2'd0, exp_addr:8'h12, exp_wdata:8'h80, exp_rdbyte:8'hFF};
        tbl[2] = '{rd:1'b0, nb:3'd2, bytes:40'h420A000000, rdat:8'h00, exp_ack:5'b00011,
                   exp_wr:2'd0, exp_rd:2'd0, exp_addr:8'h0A, exp_wdata:8'h80, exp_rdbyte:8'hFF};
        tbl[3] = '{rd:1'b1, nb:3'd1, bytes:40'h4300000000, rdat:8'h76,
                   exp_ack:(RD_EN ? 5'b00001 : 5'b00000), exp_wr:2'd0,
                   exp_rd:(RD_EN ? 2'd1 : 2'd0), exp_addr:8'h0A, exp_wdata:8'h80,
                   exp_rdbyte:(RD_EN ? 8'h76 : 8'hFF)};
        tbl[4] = '{rd:1'b0, nb:3'd5, bytes:40'h423A045566, rdat:8'h00, exp_ack:5'b00111,
                   exp_wr:2'd1, exp_rd:2'd0, exp_addr:8'h3A, exp_wdata:8'h04, exp_rdbyte:8'hFF};

        // reset state
        #2 i_rst = 1'b1;
        tick(3);
        check("reset_outputs", 32'({bus.o_wr_en, bus.o_rd_en, bus.o_busy, bus.o_addr, bus.o_wr_data}), 32'd0);
        check("reset_sda_released", 32'(sda_w), 32'd1);
        i_rst = 1'b0;
        tick(5);

        // directed table
        for (int i = 0; i < 5; i++) apply(tbl[i]);

        // repeated START after 4 address bits, then 42/11/22
        w0 = wr_cnt;
        abits = 4'b1010;
        do_start();
        send_byte(8'h42, a);
        check("rs_id_ack", 32'(a), 32'd1);
        for (int i = 3; i >= 0; i--) sbit(abits[i], s);
        do_rstart();
        send_byte(8'h42, a);
        check("rs_id2_ack", 32'(a), 32'd1);
        send_byte(8'h11, a);
        check("rs_addr_ack", 32'(a), 32'd1);
        send_byte(8'h22, a);
        check("rs_data_ack", 32'(a), 32'd1);
        do_stop(1'b1);
        check("rs_wr_strobes", 32'(wr_cnt - w0), 32'd1);
        check("rs_wr_addr", 32'(wr_addr_seen), 32'h11);
        check("rs_wr_data", 32'(wr_data_seen), 32'h22);

        // reset while the target holds the ID ACK low
        idb = 8'h42;
        do_start();
        for (int i = 7; i >= 0; i--) sbit(idb[i], s);
        m_low = 1'b0;
        tick(1);
        check("ack_driven_before_reset", 32'(sda_w), 32'd0);
        i_rst = 1'b1;
        #1;
        check("reset_mid_ack_sda", 32'(sda_w), 32'd1);
        check("reset_mid_ack_outputs", 32'({bus.o_wr_en, bus.o_rd_en, bus.o_busy, bus.o_addr, bus.o_wr_data}), 32'd0);
        tick(2);
        i_rst = 1'b0;
        ptr_m  = 8'h00;
        wdat_m = 8'h00;
        do_stop(1'b0);

        // clean transaction after reset, then random traffic
        predict(40'h425CA70000, 3, 8'h00, v);
        apply(v);
        for (int k = 0; k < 16; k++) begin
            sel = int'($urandom_range(0, 7));
            if (sel <= 4) id = 8'h42;
            else if (sel == 5) id = 8'h43;
            else id = 8'($urandom_range(0, 255));
            nb  = id[0] ? 1 : int'($urandom_range(1, 5));
            rnd = $urandom;
            predict({id, rnd}, nb, 8'($urandom_range(0, 255)), v);
            apply(v);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/sccb_target.md
# sccb_target

SCCB (I2C-like) target/responder that decodes 3-phase write and 2-phase read transactions from a camera-control master and exposes them as a simple register-bus. It oversamples `i_sclk`/`io_sda` on the system clock, detects START/STOP, matches the slave ID, drives ACK and read data open-drain, and issues single-cycle write and read strobes. It serves as the OV7670-side model in the camera-init bench and as a configurable register target in FPGA test builds.

## Interface
- `SLAVE_ID`, 8'h42: 8-bit write address; bit 0 ignored on compare, read address is `SLAVE_ID|1`.
- `i_clk`  in  1  system clock, ≥ 16× SCL rate (24 MHz nominal).
- `i_rst`  in  1  reset; asynchronous, active-high.
- `i_sclk`  in  1  SCCB clock from the master (asynchronous).
- `io_sda`  inout  1  SCCB data; driven only to 0 or `Z`, never to 1.
- `o_wr_en`  out  1  one-cycle write strobe.
- `o_addr`  out  8  register address pointer.
- `o_wr_data`  out  8  write data, valid with `o_wr_en`.
- `o_rd_en`  out  1  one-cycle read request.
- `i_rd_data`  in  8  read data, sampled 1 cycle after `o_rd_en`.
- `o_busy`  out  1  high from START until STOP.

## Operation
- `i_sclk`, `io_sda` pass through 2-FF synchronisers; one extra register provides previous values for edge detection.
- START: synced SDA falls while synced SCL is high. STOP: synced SDA rises while synced SCL is high. START in any state, including a repeated START, → `ID`; STOP in any state → `IDLE`.
- Bits are sampled MSB-first on detected SCL rising edges. The target changes SDA only on the cycle after a detected SCL falling edge.
- States: `IDLE`, `ID`, `ID_ACK`, `ADDR`, `ADDR_ACK`, `WDATA`, `WDATA_ACK`, `RDATA`, `RD_NA`, `IGNORE`.
- `ID`: receive 8 bits.
  - On upper-7 match, → `ID_ACK`.
  - On mismatch, → `IGNORE`; SDA is never driven.
- ACK states: hold SDA low from the fall of SCL edge 8 to the fall of SCL edge 9.
  - After `ID_ACK`: R/W=0 → `ADDR`; R/W=1 → `RDATA`.
- `ADDR`: 8 bits load `o_addr`, `ADDR_ACK` follows, then `WDATA`. A STOP here ends a 2-phase write: the pointer is kept and no strobe is issued.
- `WDATA`: on the 8th bit, `o_wr_data` is updated and `o_wr_en` pulses.
  - `WDATA_ACK` follows, then `IGNORE`. Extra bytes are ignored and not ACKed. No auto-increment.
- Read path, entered at `ID_ACK` with R/W=1:
  - `o_rd_en` pulses on the cycle the ACK drive starts.
  - `i_rd_data` is latched into the TX shift register on the next cycle.
  - `RDATA` places the MSB on SDA after the SCL falling edge that ends the ACK, then shifts out 8 bits. A 1 bit means SDA is released; a 0 bit means SDA is driven low.
  - `RD_NA` releases SDA and ignores the master's NA bit → `IGNORE`.
- `o_busy` = 1 in every state except `IDLE`.
- Reset values: all outputs 0, SDA released (`Z`), pointer 0, state `IDLE`.
- Reset mid-transaction: SDA is released immediately (asynchronous) and the FSM → `IDLE`. The remainder of the transaction is ignored until the next START.

## Timing
- Pin-to-event latency: 3 `i_clk` cycles (2 sync + 1 edge).
- `o_wr_en` is asserted exactly 1 cycle, on the cycle after the detected rising edge of data bit 8 (LSB). `o_addr` is stable from the end of `ADDR` through the strobe.
- `o_rd_en` is asserted 1 cycle. `i_rd_data` is sampled on the next cycle and must be valid by then.
- SDA hold after SCL falls ≥ 3 `i_clk`. SDA setup before SCL rises is ≥ half the SCL low time minus 3 `i_clk`.
- START and a SCL edge detected on the same cycle: START wins.

## Configuration
- `SCCB_TARGET_READ_EN` defined:
  - The read path (`RDATA`, `RD_NA`, `o_rd_en`) is present.
- `SCCB_TARGET_READ_EN` undefined:
  - An ID with R/W=1 goes to `IGNORE` without ACK.
  - `o_rd_en` is tied 0 and `i_rd_data` is unused.

## Test plan
- Write 42/12/80 → one `o_wr_en` pulse, `o_addr`=8'h12, `o_wr_data`=8'h80; SDA low during all three ACK bits; `o_busy` falls 3 cycles after STOP.
- Write to ID 8'h60 → no SDA drive, no strobe, `o_busy` high until STOP.
- 2-phase write 42/0A, STOP, then read 43 with `i_rd_data`=8'h76 → one `o_rd_en` with `o_addr`=8'h0A; 8'h76 seen on SDA at master SCL rising edges; SDA released at NA. Without the macro: read ID not ACKed and no `o_rd_en`.
- Write 42/3A/04/55/66 → exactly one `o_wr_en` (`o_addr`=8'h3A, data 8'h04); no ACK on 8'h55 or 8'h66.
- Repeated START after 4 address bits, then 42/11/22 → single write to `o_addr`=8'h11 with `o_wr_data`=8'h22.
- `i_rst` pulsed while the target is driving an ACK low → SDA goes `Z` the same cycle; all outputs 0; the next clean transaction completes normally.
